// File: rtl/pc_sequencer.sv
// pc_sequencer: fetch-stage program counter with prioritised next-PC
// selection (trap > redirect > return prediction > sequential step) and a
// small circular return-address stack fed by decode call/return hints.
module pc_sequencer #(
   parameter int                WIDTH        = 32,
   parameter logic [WIDTH-1:0]  RESET_VECTOR = '0,
   parameter int                STEP         = 4,
   parameter int                RAS_DEPTH    = 4
) (
   input  logic                           clk,
   input  logic                           reset_n,
   input  logic                           en,
   input  logic                           trap,
   input  logic [WIDTH-1:0]               trap_vector,
   input  logic                           load,
   input  logic [WIDTH-1:0]               target,
   input  logic                           call,
   input  logic                           ret,
   input  logic                           flush,
   output logic [WIDTH-1:0]               pc,
   output logic [WIDTH-1:0]               pc_plus_step,
   output logic [WIDTH-1:0]               ras_top,
   output logic [$clog2(RAS_DEPTH):0]     ras_count,
   output logic                           ras_empty,
   output logic                           ras_miss,
   output logic                           misaligned
);

   localparam int PW = $clog2(RAS_DEPTH);
   localparam int CW = PW + 1;

   logic [WIDTH-1:0] ras_mem [RAS_DEPTH];
   logic [PW-1:0]    wr_ptr;
   logic [PW-1:0]    top_ptr;
   logic             ras_full;
   logic             ras_act;
   logic             do_push;
   logic             do_replace;
   logic             do_pop;
   logic             miss_set;
   logic [WIDTH-1:0] pc_next;

   // Outputs derived purely from registered state
   always_comb begin
      pc_plus_step = pc + WIDTH'(STEP);
      misaligned   = (pc[1:0] != 2'b00);
      top_ptr      = wr_ptr - PW'(1);
      ras_empty    = (ras_count == '0);
      ras_full     = (ras_count == CW'(RAS_DEPTH));
      ras_top      = ras_empty ? '0 : ras_mem[top_ptr];
   end

   // Decide stack action and next PC; trap and flush both suppress RAS moves
   always_comb begin
      ras_act    = en & ~trap & ~flush;
      do_replace = ras_act & call & ret & ~ras_empty;
      do_push    = ras_act & call & ~do_replace;
      do_pop     = ras_act & ret & ~call & ~ras_empty;
      // A return that falls through to the sequential step had no prediction
      miss_set   = en & ~trap & ~load & ret & ras_empty;
      if (trap)
         pc_next = trap_vector;
      else if (load)
         pc_next = target;
      else if (ret && !ras_empty)
         pc_next = ras_top;
      else
         pc_next = pc_plus_step;
   end

   // PC and miss flag advance only when enabled
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         pc       <= RESET_VECTOR;
         ras_miss <= 1'b0;
      end else if (en) begin
         pc       <= pc_next;
         ras_miss <= miss_set;
      end
   end

   // Stack pointer and occupancy; flush acts even while stalled
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         wr_ptr    <= '0;
         ras_count <= '0;
      end else if (flush) begin
         wr_ptr    <= '0;
         ras_count <= '0;
      end else if (do_push) begin
         wr_ptr <= wr_ptr + PW'(1);
         if (!ras_full)
            ras_count <= ras_count + CW'(1);
      end else if (do_pop) begin
         wr_ptr    <= top_ptr;
         ras_count <= ras_count - CW'(1);
      end
   end

   // Stack storage; when full the push lands on the oldest slot
   always_ff @(posedge clk) begin
      if (do_push)
         ras_mem[wr_ptr] <= pc_plus_step;
      else if (do_replace)
         ras_mem[top_ptr] <= pc_plus_step;
   end

endmodule

// File: tb/tb_pc_sequencer.sv
// tb_pc_sequencer: directed vectors for pc_sequencer with hand-computed
// expectations; a 32-bit instance covers sequencing/RAS, an 8-bit one wrap.
module tb_pc_sequencer;

   logic        clk = 1'b0;
   logic        reset_n;
   logic        en, trap, load, call, ret, flush;
   logic [31:0] trap_vector, target;
   logic [31:0] pc, pc_plus_step, ras_top;
   logic [2:0]  ras_count;
   logic        ras_empty, ras_miss, misaligned;

   logic        en_b, load_b;
   logic [7:0]  target_b;
   logic [7:0]  pc_b, pcs_b, top_b;
   logic [2:0]  cnt_b;
   logic        empty_b, miss_b, mis_b;

   int tests = 0;
   int fails = 0;

   always #5 clk = ~clk;

   pc_sequencer #(.WIDTH(32), .RESET_VECTOR(32'h100), .STEP(4), .RAS_DEPTH(4)) dut (
      .clk(clk), .reset_n(reset_n), .en(en), .trap(trap), .trap_vector(trap_vector),
      .load(load), .target(target), .call(call), .ret(ret), .flush(flush),
      .pc(pc), .pc_plus_step(pc_plus_step), .ras_top(ras_top), .ras_count(ras_count),
      .ras_empty(ras_empty), .ras_miss(ras_miss), .misaligned(misaligned)
   );

   pc_sequencer #(.WIDTH(8), .RESET_VECTOR(8'hFC), .STEP(4), .RAS_DEPTH(4)) dut_b (
      .clk(clk), .reset_n(reset_n), .en(en_b), .trap(1'b0), .trap_vector(8'h00),
      .load(load_b), .target(target_b), .call(1'b0), .ret(1'b0), .flush(1'b0),
      .pc(pc_b), .pc_plus_step(pcs_b), .ras_top(top_b), .ras_count(cnt_b),
      .ras_empty(empty_b), .ras_miss(miss_b), .misaligned(mis_b)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      tests++;
      if (got !== exp) begin
         fails++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // Advance one edge, then settle so outputs are sampled off the edge
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      trap = 0; load = 0; call = 0; ret = 0; flush = 0;
   endtask

   initial begin
      #50000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      reset_n = 0; en = 0; idle(); trap_vector = 0; target = 0;
      en_b = 0; load_b = 0; target_b = 0;
      #23;
      chk("rst_pc",    pc, 32'h100);
      chk("rst_cnt",   32'(ras_count), 32'd0);
      chk("rst_empty", 32'(ras_empty), 32'd1);
      chk("rst_miss",  32'(ras_miss), 32'd0);
      chk("rst_top",   ras_top, 32'h0);
      chk("rst_pc_b",  32'(pc_b), 32'hFC);

      // Reset and step
      @(posedge clk); #1; reset_n = 1; en = 1;
      tick(); chk("step1", pc, 32'h104);
      tick(); chk("step2", pc, 32'h108);
      tick(); chk("step3", pc, 32'h10C);
      #2; reset_n = 0; #1;
      chk("async_rst", pc, 32'h100);
      @(posedge clk); #1; reset_n = 1;

      // Priority: trap beats load and suppresses the call push
      load = 1; target = 32'h200; tick(); chk("ld200", pc, 32'h200);
      trap = 1; load = 1; call = 1; trap_vector = 32'h80; target = 32'h400;
      tick(); chk("trap_pc", pc, 32'h80); chk("trap_cnt", 32'(ras_count), 32'd0);
      idle(); load = 1; target = 32'h400;
      tick(); chk("load_pc", pc, 32'h400);

      // Call / return
      target = 32'h10; tick();
      idle(); call = 1; tick();
      chk("c1_top", ras_top, 32'h14); chk("c1_cnt", 32'(ras_count), 32'd1);
      idle(); load = 1; target = 32'h50; tick();
      idle(); call = 1; tick();
      chk("c2_top", ras_top, 32'h54); chk("c2_cnt", 32'(ras_count), 32'd2);
      idle(); load = 1; target = 32'h300; tick();
      idle(); ret = 1; tick();
      chk("r1_pc", pc, 32'h54); chk("r1_top", ras_top, 32'h14);
      tick();
      chk("r2_pc", pc, 32'h14); chk("r2_empty", 32'(ras_empty), 32'd1);
      tick();
      chk("r3_pc", pc, 32'h18); chk("r3_miss", 32'(ras_miss), 32'd1);
      idle(); tick();
      chk("miss_clr", 32'(ras_miss), 32'd0); chk("r3_step", pc, 32'h1C);

      // Overflow: five pushes into four slots, oldest (0x4) overwritten
      load = 1; target = 32'h0; tick();
      call = 1;
      for (int i = 1; i <= 5; i++) begin
         target = (i == 5) ? 32'h100 : 32'(i * 16);
         tick();
      end
      chk("ovf_cnt", 32'(ras_count), 32'd4);
      chk("ovf_top", ras_top, 32'h44);
      idle(); ret = 1;
      tick(); chk("ovf_r1", pc, 32'h44);
      tick(); chk("ovf_r2", pc, 32'h34);
      tick(); chk("ovf_r3", pc, 32'h24);
      tick(); chk("ovf_r4", pc, 32'h14);
      chk("ovf_miss0", 32'(ras_miss), 32'd0);
      tick(); chk("ovf_r5", pc, 32'h18); chk("ovf_miss", 32'(ras_miss), 32'd1);

      // Stall holds everything, including the miss flag
      idle(); call = 1; tick();
      chk("st_push", ras_top, 32'h1C); chk("st_pc", pc, 32'h1C);
      en = 0; call = 1; ret = 1; tick(); tick();
      chk("stall_pc", pc, 32'h1C); chk("stall_cnt", 32'(ras_count), 32'd1);
      chk("stall_top", ras_top, 32'h1C);

      // Simultaneous call+ret replaces top
      en = 1; idle(); load = 1; target = 32'h500; tick();
      idle(); call = 1; ret = 1; tick();
      chk("cr_pc", pc, 32'h1C); chk("cr_top", ras_top, 32'h504);
      chk("cr_cnt", 32'(ras_count), 32'd1);

      // Flush while stalled
      idle(); en = 0; flush = 1; call = 1; tick();
      chk("fl_cnt", 32'(ras_count), 32'd0); chk("fl_top", ras_top, 32'h0);
      chk("fl_pc", pc, 32'h1C);

      // ret with load: target wins but stack still pops
      en = 1; idle(); call = 1; tick();
      chk("rl_push", ras_top, 32'h20);
      idle(); ret = 1; load = 1; target = 32'h700; tick();
      chk("rl_pc", pc, 32'h700); chk("rl_cnt", 32'(ras_count), 32'd0);
      chk("rl_miss", 32'(ras_miss), 32'd0);
      idle();

      // 8-bit wrap-around and misalignment
      en_b = 1; tick();
      chk("wrap_pc", 32'(pc_b), 32'h00); chk("wrap_mis", 32'(mis_b), 32'd0);
      load_b = 1; target_b = 8'h02; tick();
      chk("mis_pc", 32'(pc_b), 32'h02); chk("mis_flag", 32'(mis_b), 32'd1);
      chk("mis_pps", 32'(pcs_b), 32'h06);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
